// File: rtl/uart_rx_pkg.sv
// Shared types, line-level constants and parity helper for the uart_rx receiver.
package uart_rx_pkg;

    localparam int unsigned MAX_DATA_WIDTH = 9;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Parity bit that makes the ones count over data+parity odd; zero-extension is harmless.
    function automatic logic odd_parity(input logic [MAX_DATA_WIDTH-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line; resets to the idle (high) level.
module uart_rx_sync
    import uart_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= IDLE_LEVEL;
            s2_q <= IDLE_LEVEL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// One-sample-per-bit UART receiver: start, DATA_WIDTH bits LSB-first, odd parity, stop.
// Optional parity enforcement is enabled by defining UART_RX_PARITY_CHECK_EN.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  uart_clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_out,
    output logic                  rx_done
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    logic                  rxs;
    rx_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rx_out_q, rx_out_d;
    logic                  rx_done_q, rx_done_d;
    logic                  frame_ok;

    uart_rx_sync u_sync (
        .clk (uart_clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rxs)
    );

`ifdef UART_RX_PARITY_CHECK_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (state_q == PARITY) begin
            parity_d = rxs;
        end
    end

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign frame_ok = (parity_q == odd_parity(MAX_DATA_WIDTH'(shift_q)));
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            rx_out_q  <= '0;
            rx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            rx_out_q  <= rx_out_d;
            rx_done_q <= rx_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        rx_out_d  = rx_out_q;
        rx_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rxs == START_BIT) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                shift_d = {rxs, shift_q[DATA_WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                if (rxs == STOP_BIT) begin
                    state_d = IDLE;
                    if (frame_ok) begin
                        rx_out_d  = shift_q;
                        rx_done_d = 1'b1;
                    end
                end else begin
                    // Framing error: wait for the line to return high before hunting for a start bit.
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rxs == IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_out  = rx_out_q;
    assign rx_done = rx_done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (DATA_WIDTH = 8).
module tb_uart_rx;

    logic       uart_clk;
    logic       rst;
    logic       rx_in;
    logic [7:0] rx_out;
    logic       rx_done;

    int vectors    = 0;
    int miscompares = 0;

    int         cyc = 0;
    int         pulse_cnt = 0;
    int         pulse_cyc[$];
    logic [7:0] pulse_data[$];

    uart_rx #(.DATA_WIDTH(8)) dut (
        .uart_clk (uart_clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .rx_out   (rx_out),
        .rx_done  (rx_done)
    );

    initial uart_clk = 1'b0;
    always #5 uart_clk = ~uart_clk;

    always @(posedge uart_clk) cyc <= cyc + 1;

    // Pulse log: every cycle rx_done is high, remember when and what word was shown.
    always @(negedge uart_clk) begin
        if (rx_done === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_cyc.push_back(cyc);
            pulse_data.push_back(rx_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one bit; it is sampled by the next rising edge.
    task automatic bit_out(input logic b);
        rx_in = b;
        @(posedge uart_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        bit_out(par);
        bit_out(stp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bit_out(1'b1);
    endtask

    int p0;

    initial begin
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(posedge uart_clk);
        #1;
        check("reset_rx_out", 32'(rx_out), 32'h0);
        check("reset_rx_done", 32'(rx_done), 32'h0);
        rst = 1'b0;

        // Idle line after reset produces nothing.
        idle(4);
        check("idle_pulses", 32'(pulse_cnt), 32'd0);
        check("idle_rx_out", 32'(rx_out), 32'h0);

        // 0x55 with exact latency: rx_done high only after the 3rd edge following the stop bit.
        send_frame(8'h55, 1'b1, 1'b1);
        check("lat_edge1", 32'(rx_done), 32'h0);
        bit_out(1'b1);
        check("lat_edge2", 32'(rx_done), 32'h0);
        bit_out(1'b1);
        check("lat_edge3", 32'(rx_done), 32'h1);
        check("lat_rx_out", 32'(rx_out), 32'h55);
        bit_out(1'b1);
        check("lat_edge4", 32'(rx_done), 32'h0);
        check("hold_rx_out", 32'(rx_out), 32'h55);
        check("x55_pulses", 32'(pulse_cnt), 32'd1);

        // Back-to-back 0xA5 and 0x3C with no idle gap.
        p0 = pulse_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(4);
        check("b2b_pulses", 32'(pulse_cnt - p0), 32'd2);
        if (pulse_cnt - p0 == 2) begin
            check("b2b_word0", 32'(pulse_data[p0]), 32'hA5);
            check("b2b_word1", 32'(pulse_data[p0 + 1]), 32'h3C);
            check("b2b_spacing", 32'(pulse_cyc[p0 + 1] - pulse_cyc[p0]), 32'd11);
        end
        check("b2b_rx_out", 32'(rx_out), 32'h3C);

        // Framing error on 0x0F, line held low, then recovery with 0x81.
        p0 = pulse_cnt;
        send_frame(8'h0F, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) bit_out(1'b0);
        idle(2);
        check("frm_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        check("frm_rx_out_kept", 32'(rx_out), 32'h3C);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(4);
        check("frm_recover_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("frm_recover_rx_out", 32'(rx_out), 32'h81);

        // Reset during data bit 4 aborts the frame.
        p0 = pulse_cnt;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        rst = 1'b1;
        bit_out(1'b1);
        bit_out(1'b1);
        check("abort_rx_out", 32'(rx_out), 32'h0);
        check("abort_rx_done", 32'(rx_done), 32'h0);
        rst = 1'b0;
        idle(6);
        check("abort_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        send_frame(8'h00, 1'b1, 1'b1);
        idle(4);
        check("after_abort_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("after_abort_rx_out", 32'(rx_out), 32'h00);

        // 0x55 with wrong parity (0).
        p0 = pulse_cnt;
        send_frame(8'h55, 1'b0, 1'b1);
        idle(4);
`ifdef UART_RX_PARITY_CHECK_EN
        check("badpar_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("badpar_rx_out", 32'(rx_out), 32'h00);
`else
        check("badpar_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("badpar_rx_out", 32'(rx_out), 32'h55);
`endif

        // A good frame still follows cleanly.
        p0 = pulse_cnt;
        send_frame(8'hC3, 1'b1, 1'b1);
        idle(4);
        check("final_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("final_rx_out", 32'(rx_out), 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
